// File: rtl/bus_fabric_pkg.sv
// ---------------------------------------------------------------------------
// bus_fabric_pkg
// Shared types and helpers for the bus response fabric.
//   state_e      : response FSM states (IDLE, WAIT, ACK, ERROR)
//   ERR_SAT      : value at which the bus-error counter stops counting
//   WS_MAX_BITS  : widest packed wait-state table wait_field() can index
//   idx_width()  : width of a slave index for n slaves (at least 1 bit)
//   wait_field() : extract the w-bit wait-state field of slave idx
// ---------------------------------------------------------------------------
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    ERROR = 2'd3
  } state_e;

  localparam logic [7:0] ERR_SAT     = 8'd255;
  localparam int         WS_MAX_BITS = 1024;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Field idx of a packed table of w-bit entries; entry 0 sits at the LSBs.
  function automatic logic [31:0] wait_field(input logic [WS_MAX_BITS-1:0] ws,
                                             input int unsigned idx,
                                             input int unsigned w);
    logic [WS_MAX_BITS-1:0] sh;
    sh = ws >> (idx * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/bus_response_mux_if.sv
// ---------------------------------------------------------------------------
// bus_response_mux_if
// Bundles the CPU-side strobe/ack signals and the slave-side select, data
// and ready signals seen by the response multiplexer.
//   master modport : the CPU / decoder / slaves side (drives strobes, selects,
//                    read data, ready; observes ack, error, data out)
//   slave modport  : the response multiplexer itself
// Signals:
//   AS_L, WE_L        CPU address strobe / write enable, active low
//   Select_H          decoder selects, one-hot expected
//   DataIn            slave read data, slave i at [i*DATA_W +: DATA_W]
//   Ready_H           per-slave ready
//   DataOut_CPU       registered read data to the CPU
//   DTAck_H           transfer acknowledge
//   Bus_Error_H       acknowledged transfer ended in error
//   Active_Slave      index of the latched slave
//   Error_Count       saturating bus-error count
// Handshake: a transfer is requested while AS_L is low; DTAck_H rises once
// the transfer is done (with Bus_Error_H qualifying it) and stays high until
// AS_L is seen high, after which DTAck_H drops on the following edge.
// ---------------------------------------------------------------------------
interface bus_response_mux_if
  import bus_fabric_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int DATA_W     = 32
);
  localparam int IDX_W = idx_width(NUM_SLAVES);

  logic                         AS_L;
  logic                         WE_L;
  logic [NUM_SLAVES-1:0]        Select_H;
  logic [NUM_SLAVES*DATA_W-1:0] DataIn;
  logic [NUM_SLAVES-1:0]        Ready_H;
  logic [DATA_W-1:0]            DataOut_CPU;
  logic                         DTAck_H;
  logic                         Bus_Error_H;
  logic [IDX_W-1:0]             Active_Slave;
  logic [7:0]                   Error_Count;

  modport master (
    output AS_L, WE_L, Select_H, DataIn, Ready_H,
    input  DataOut_CPU, DTAck_H, Bus_Error_H, Active_Slave, Error_Count
  );

  modport slave (
    input  AS_L, WE_L, Select_H, DataIn, Ready_H,
    output DataOut_CPU, DTAck_H, Bus_Error_H, Active_Slave, Error_Count
  );

endinterface

// File: rtl/select_encoder.sv
// ---------------------------------------------------------------------------
// select_encoder
// Combinational one-hot to binary encoder with a validity flag.
//   sel_i          : in  NUM   decoder select lines
//   index_o        : out IDX_W index of the set bit (meaningful when valid)
//   onehot_valid_o : out 1     exactly one select bit is set
// ---------------------------------------------------------------------------
module select_encoder
  import bus_fabric_pkg::*;
#(
  parameter int NUM = 8
) (
  input  logic [NUM-1:0]            sel_i,
  output logic [idx_width(NUM)-1:0] index_o,
  output logic                      onehot_valid_o
);
  localparam int IDX_W = idx_width(NUM);

  always_comb begin
    index_o        = '0;
    onehot_valid_o = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (sel_i[i]) index_o = IDX_W'(i);
    end
    // Non-zero and clearing the lowest set bit leaves nothing.
    onehot_valid_o = (sel_i != '0) && ((sel_i & (sel_i - NUM'(1))) == '0);
  end

endmodule

// File: rtl/bus_response_mux.sv
// ---------------------------------------------------------------------------
// bus_response_mux
// Registered read-data multiplexer and DTAck generator between the address
// decoder / slave peripherals and the CPU data-in bus.
// Ports:
//   Clock        in   system clock
//   Reset_L      in   asynchronous active-low reset
//   bus          slave modport of bus_response_mux_if (strobes, selects,
//                slave data/ready in; data out, DTAck, error, index, count)
//   dbg_state_o  out  current response FSM state
// Each slave completes either after a fixed number of wait states or when
// its Ready_H bit rises (bounded by TIMEOUT). Invalid selects and ready
// timeouts are acknowledged with Bus_Error_H and counted.
// ---------------------------------------------------------------------------
module bus_response_mux
  import bus_fabric_pkg::*;
#(
  parameter int                          NUM_SLAVES  = 8,
  parameter int                          DATA_W      = 32,
  parameter int                          WAIT_W      = 4,
  parameter logic [NUM_SLAVES*WAIT_W-1:0] WAIT_STATES = '0,
  parameter logic [NUM_SLAVES-1:0]        READY_MODE  = '0,
  parameter int                          TIMEOUT     = 255
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  bus_response_mux_if.slave     bus,
  output state_e                dbg_state_o
);
  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  // Wait-state table widened to the helper's fixed argument width.
  localparam logic [WS_MAX_BITS-1:0] WS_EXT = WS_MAX_BITS'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          errcnt_q, errcnt_d;

  logic [IDX_W-1:0]    sel_idx;
  logic                sel_ok;
  logic [WAIT_W-1:0]   wait_sel;
  logic                enter_ack;
  logic                enter_err;
  logic [IDX_W-1:0]    cap_idx;

  select_encoder #(.NUM(NUM_SLAVES)) u_sel_enc (
    .sel_i          (bus.Select_H),
    .index_o        (sel_idx),
    .onehot_valid_o (sel_ok)
  );

  assign wait_sel = WAIT_W'(wait_field(WS_EXT, 32'(sel_idx), WAIT_W));

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
      data_q   <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      data_q   <= data_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    data_d    = data_q;
    errcnt_d  = errcnt_q;
    enter_ack = 1'b0;
    enter_err = 1'b0;
    cap_idx   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.AS_L) begin
          if (!sel_ok) begin
            enter_err = 1'b1;
          end else begin
            idx_d   = sel_idx;
            // A zero-wait slave is captured on this same edge, before
            // idx_q holds the new index.
            cap_idx = sel_idx;
            if (READY_MODE[sel_idx]) begin
              state_d = WAIT;
              tcnt_d  = '0;
            end else if (wait_sel == '0) begin
              enter_ack = 1'b1;
            end else begin
              state_d = WAIT;
              wcnt_d  = wait_sel;
            end
          end
        end
      end

      WAIT: begin
        // Strobe withdrawn: abandon silently, nothing acknowledged or counted.
        if (bus.AS_L) begin
          state_d = IDLE;
        end else if (READY_MODE[idx_q]) begin
          if (bus.Ready_H[idx_q]) begin
            enter_ack = 1'b1;
          end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
            // This increment would reach TIMEOUT.
            enter_err = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end else begin
          if (wcnt_q == WAIT_W'(1)) enter_ack = 1'b1;
          else                      wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end

      ACK, ERROR: begin
        if (bus.AS_L) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (enter_ack) begin
      state_d = ACK;
      // Writes leave the read register untouched.
      if (bus.WE_L) data_d = bus.DataIn[cap_idx*DATA_W +: DATA_W];
    end

    if (enter_err) begin
      state_d = ERROR;
      data_d  = '0;
      if (errcnt_q != ERR_SAT) errcnt_d = errcnt_q + 8'd1;
    end
  end

  // All outputs decode registered state only.
  assign bus.DTAck_H      = (state_q == ACK) || (state_q == ERROR);
  assign bus.Bus_Error_H  = (state_q == ERROR);
  assign bus.DataOut_CPU  = data_q;
  assign bus.Active_Slave = idx_q;
  assign bus.Error_Count  = errcnt_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_bus_response_mux.sv
// ---------------------------------------------------------------------------
// tb_bus_response_mux
// Self-checking bench for bus_response_mux with 8 slaves: directed cases for
// zero/fixed wait, ready mode with and without timeout, invalid selects,
// counter saturation, strobe abort and asynchronous reset, followed by
// randomized transfers. Expected outcomes come from a transaction-level model
// (latency, error/abort decision) held in this file.
// ---------------------------------------------------------------------------
module tb_bus_response_mux;
  import bus_fabric_pkg::*;

  localparam int          NS = 8;
  localparam int          DW = 32;
  localparam int          TO = 10;
  localparam logic [31:0] WS = 32'h5032_8001;
  localparam logic [7:0]  RM = 8'h02;

  // Same tables written out per slave, as the model reads them.
  int wait_tab [NS] = '{1, 0, 0, 8, 2, 3, 0, 5};
  bit rm_tab   [NS] = '{0, 1, 0, 0, 0, 0, 0, 0};

  logic   Clock = 1'b0;
  logic   Reset_L;
  state_e dbg_state;

  bus_response_mux_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus_if ();

  bus_response_mux #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .WAIT_W     (4),
    .WAIT_STATES(WS),
    .READY_MODE (RM),
    .TIMEOUT    (TO)
  ) dut (
    .Clock      (Clock),
    .Reset_L    (Reset_L),
    .bus        (bus_if),
    .dbg_state_o(dbg_state)
  );

  always #5 Clock = ~Clock;

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_data   = '0;
  int          exp_errcnt = 0;
  int          exp_active = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_dtack"}, 32'(bus_if.DTAck_H), 32'd0);
    check_val({tag, "_berr"},  32'(bus_if.Bus_Error_H), 32'd0);
    check_val({tag, "_data"},  bus_if.DataOut_CPU, 32'd0);
    check_val({tag, "_act"},   32'(bus_if.Active_Slave), 32'd0);
    check_val({tag, "_ecnt"},  32'(bus_if.Error_Count), 32'd0);
    check_val({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // One transfer, started from a negedge with AS_L high beforehand.
  //   rdy_d  : edge offset from E0 where the latched slave's Ready_H is first
  //            sampled high (0 or > TO means never)
  //   abort_h: edge offset where AS_L is first sampled high (0 = after ack)
  task automatic run_txn(input logic [7:0] sel, input bit write, input int rdy_d,
                         input int abort_h, input logic [31:0] dval, input string nm);
    int          idx, lat, h, fin;
    bit          ok, rmode, is_err, aborted, rdy_valid;
    logic [31:0] prev_data, new_data;
    int          prev_cnt, new_cnt, prev_act, new_act;
    bit          exp_ack;
    logic [31:0] exp_dout;

    // ---- transaction-level reference model ----
    ok  = ($countones(sel) == 1);
    idx = 0;
    for (int i = 0; i < NS; i++) if (sel[i]) idx = i;
    rmode     = ok && rm_tab[idx];
    rdy_valid = (rdy_d >= 1) && (rdy_d <= TO);
    if (!ok)        begin is_err = 1; lat = 0; end
    else if (rmode) begin is_err = !rdy_valid; lat = rdy_valid ? rdy_d : TO; end
    else            begin is_err = 0; lat = wait_tab[idx]; end
    aborted = ok && (abort_h > 0) && (abort_h <= lat);
    h       = aborted ? abort_h : lat + 1 + int'($urandom_range(0, 2));
    fin     = aborted ? h : lat;

    prev_data = exp_data;
    prev_cnt  = exp_errcnt;
    prev_act  = exp_active;
    new_data  = prev_data;
    new_cnt   = prev_cnt;
    new_act   = ok ? idx : prev_act;
    if (!aborted) begin
      if (is_err) begin
        new_data = '0;
        new_cnt  = (prev_cnt < 255) ? prev_cnt + 1 : 255;
      end else if (!write) begin
        new_data = dval;
      end
    end
    exp_data   = new_data;
    exp_errcnt = new_cnt;
    exp_active = new_act;
    exp_q.push_back(new_data);

    // ---- drive the request ----
    bus_if.AS_L     = 1'b0;
    bus_if.WE_L     = write ? 1'b0 : 1'b1;
    bus_if.Select_H = sel;
    for (int j = 0; j < NS; j++) bus_if.DataIn[j*DW +: DW] = $urandom;
    if (ok) bus_if.DataIn[idx*DW +: DW] = dval;
    bus_if.Ready_H = 8'($urandom);
    if (rmode) bus_if.Ready_H[idx] = 1'b0;

    for (int k = 0; k <= h; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      exp_ack  = !aborted && (k >= lat) && (k < h);
      exp_dout = (!aborted && k >= lat) ? new_data : prev_data;
      check_val($sformatf("%s_dtack@%0d", nm, k), 32'(bus_if.DTAck_H), 32'(exp_ack));
      check_val($sformatf("%s_berr@%0d", nm, k), 32'(bus_if.Bus_Error_H), 32'(exp_ack && is_err));
      if (k == fin) check_val($sformatf("%s_data@%0d", nm, k), bus_if.DataOut_CPU, exp_q.pop_front());
      else          check_val($sformatf("%s_data@%0d", nm, k), bus_if.DataOut_CPU, exp_dout);
      check_val($sformatf("%s_act@%0d", nm, k), 32'(bus_if.Active_Slave), 32'(new_act));
      check_val($sformatf("%s_ecnt@%0d", nm, k), 32'(bus_if.Error_Count),
                32'((!aborted && k >= lat) ? new_cnt : prev_cnt));

      // Inputs for the next edge; everything except the latched slave's
      // data and ready is scrambled and must be ignored.
      if (k + 1 == h) bus_if.AS_L = 1'b1;
      bus_if.Select_H = 8'($urandom);
      for (int j = 0; j < NS; j++)
        if (!ok || j != idx) bus_if.DataIn[j*DW +: DW] = $urandom;
      bus_if.Ready_H = 8'($urandom);
      if (rmode) bus_if.Ready_H[idx] = rdy_valid && (k + 1 >= rdy_d);
    end
  endtask

  // Start a read, then pull reset asynchronously after edge E0+after_k.
  task automatic reset_mid(input logic [7:0] sel, input int after_k,
                           input bit exp_ack, input string nm);
    bus_if.AS_L     = 1'b0;
    bus_if.WE_L     = 1'b1;
    bus_if.Select_H = sel;
    bus_if.Ready_H  = '0;
    for (int j = 0; j < NS; j++) bus_if.DataIn[j*DW +: DW] = $urandom;
    for (int k = 0; k <= after_k; k++) begin
      @(posedge Clock);
      @(negedge Clock);
    end
    check_val({nm, "_pre_dtack"}, 32'(bus_if.DTAck_H), 32'(exp_ack));
    Reset_L = 1'b0;
    #1;
    check_idle_outputs(nm);
    bus_if.AS_L = 1'b1;
    #1;
    Reset_L    = 1'b1;
    exp_data   = '0;
    exp_errcnt = 0;
    exp_active = 0;
    exp_q.delete();
    @(negedge Clock);
  endtask

  initial begin
    logic [7:0] rsel;
    int         r, a, b, ab;

    Reset_L         = 1'b0;
    bus_if.AS_L     = 1'b1;
    bus_if.WE_L     = 1'b1;
    bus_if.Select_H = '0;
    bus_if.Ready_H  = '0;
    bus_if.DataIn   = '0;
    repeat (3) @(negedge Clock);
    check_idle_outputs("reset");
    Reset_L = 1'b1;
    @(negedge Clock);

    // Zero-wait read from slave 2.
    run_txn(8'h04, 0, 0, 0, 32'hDEADBEEF, "zero_wait_rd");
    // Three wait states, read then write on slave 5.
    run_txn(8'h20, 0, 0, 0, $urandom, "ws3_rd");
    run_txn(8'h20, 1, 0, 0, $urandom, "ws3_wr");
    // Ready-mode slave 1: ready at E0+7, then never ready (timeout).
    run_txn(8'h02, 0, 7, 0, $urandom, "ready7");
    run_txn(8'h02, 0, 0, 0, $urandom, "timeout");
    // Invalid selects.
    run_txn(8'h00, 0, 0, 0, $urandom, "sel_none");
    run_txn(8'h09, 0, 0, 0, $urandom, "sel_multi");
    // Strobe released during 8 wait states, then a normal transfer.
    run_txn(8'h08, 0, 0, 4, $urandom, "abort");
    run_txn(8'h08, 0, 0, 0, $urandom, "after_abort");
    // Ready sampled high at the first possible edge, and at the last one.
    run_txn(8'h02, 0, 1, 0, $urandom, "ready1");
    run_txn(8'h02, 0, TO, 0, $urandom, "ready_last");

    // Randomized transfers.
    for (int t = 0; t < 150; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        rsel = 8'h00;
      end else if (r == 1) begin
        a    = int'($urandom_range(0, 7));
        b    = (a + int'($urandom_range(1, 7))) % NS;
        rsel = (8'h01 << a) | (8'h01 << b);
      end else begin
        rsel = 8'h01 << $urandom_range(0, 7);
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      run_txn(rsel, bit'($urandom_range(0, 1)), int'($urandom_range(1, TO + 3)), ab,
              $urandom, $sformatf("rnd%0d", t));
    end

    // Drive the error counter well past saturation.
    for (int t = 0; t < 300; t++) run_txn(8'h00, 0, 0, 0, $urandom, "sat");
    check_val("sat_final", 32'(bus_if.Error_Count), 32'd255);

    // Reset during WAIT and during ACK; each followed by a clean transfer.
    reset_mid(8'h08, 3, 1'b0, "rst_wait");
    run_txn(8'h04, 0, 0, 0, $urandom, "post_rst_wait");
    reset_mid(8'h04, 1, 1'b1, "rst_ack");
    run_txn(8'h20, 0, 0, 0, $urandom, "post_rst_ack");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
